// File: rtl/mouse_btn_pkg.sv
// Shared types and constants for the mouse button gesture controller.
package mouse_btn_pkg;

    typedef enum logic [1:0] {
        EvtClick   = 2'd0,
        EvtDouble  = 2'd1,
        EvtLong    = 2'd2,
        EvtLongEnd = 2'd3
    } evt_t;

    typedef enum logic [2:0] {
        StIdle,
        StPress1,
        StGap,
        StPress2,
        StHeld,
        StWaitRel
    } btn_state_t;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_MID   = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mouse_btn_classifier.sv
// Per-button gesture FSM with ms timer and a one-entry pending event register.
// MOUSE_BTN_LEVEL_EN adds o_active (button held in a press-like state).
module mouse_btn_classifier
    import mouse_btn_pkg::*;
#(
    parameter int unsigned LONG_MS = 500,
    parameter int unsigned DBL_MS  = 250
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_pos,
    input  logic       i_neg,
    input  logic       i_clr,
    output logic       o_pend_valid,
    output logic [1:0] o_pend_type,
    output logic       o_drop
`ifdef MOUSE_BTN_LEVEL_EN
    ,
    output logic       o_active
`endif
);

    localparam int unsigned TW = $clog2(max_u(LONG_MS, DBL_MS) + 1);
    localparam logic [TW-1:0] T_LONG = TW'(LONG_MS);
    localparam logic [TW-1:0] T_DBL  = TW'(DBL_MS);
    localparam logic [TW-1:0] T_SAT  = '1;

    btn_state_t    state_q, state_d;
    logic [TW-1:0] timer_q;
    logic          pos_e, neg_e, emit;
    evt_t          emit_type;
    logic          pend_valid_q;
    evt_t          pend_type_q;

    // Edges win over timeouts because they are tested first in each state.
    always_comb begin
        pos_e     = i_pos & ~i_neg;
        neg_e     = i_neg & ~i_pos;
        state_d   = state_q;
        emit      = 1'b0;
        emit_type = EvtClick;
        case (state_q)
            StIdle: if (pos_e) state_d = StPress1;
            StPress1: begin
                if (neg_e) begin
                    state_d = StGap;
                end else if (timer_q == T_LONG) begin
                    emit = 1'b1; emit_type = EvtLong; state_d = StHeld;
                end
            end
            StGap: begin
                if (pos_e) begin
                    state_d = StPress2;
                end else if (timer_q == T_DBL) begin
                    emit = 1'b1; emit_type = EvtClick; state_d = StIdle;
                end
            end
            StPress2: begin
                if (neg_e) begin
                    emit = 1'b1; emit_type = EvtDouble; state_d = StIdle;
                end else if (timer_q == T_LONG) begin
                    emit = 1'b1; emit_type = EvtDouble; state_d = StWaitRel;
                end
            end
            StHeld: begin
                if (neg_e) begin
                    emit = 1'b1; emit_type = EvtLongEnd; state_d = StIdle;
                end
            end
            StWaitRel: if (neg_e) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A slot being drained this cycle can take the new event without loss.
    assign o_drop = emit & pend_valid_q & ~i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= EvtClick;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (i_tick && timer_q != T_SAT) begin
                timer_q <= timer_q + 1'b1;
            end
            if (emit && (!pend_valid_q || i_clr)) begin
                pend_valid_q <= 1'b1;
                pend_type_q  <= emit_type;
            end else if (i_clr) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign o_pend_valid = pend_valid_q;
    assign o_pend_type  = pend_type_q;

`ifdef MOUSE_BTN_LEVEL_EN
    assign o_active = (state_q == StPress1) | (state_q == StPress2) |
                      (state_q == StHeld)   | (state_q == StWaitRel);
`endif

endmodule

// File: rtl/mouse_btn_ctrl.sv
// Mouse button gesture controller: ms prescaler, per-button classifiers, round-robin event output.
// MOUSE_BTN_LEVEL_EN adds the registered o_btn_level output.
module mouse_btn_ctrl
    import mouse_btn_pkg::*;
#(
    parameter int unsigned N_BTN    = 3,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned LONG_MS  = 500,
    parameter int unsigned DBL_MS   = 250
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_BTN-1:0]         i_pos,
    input  logic [N_BTN-1:0]         i_neg,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [$clog2(N_BTN)-1:0] o_evt_btn,
    output logic [1:0]               o_evt_type,
    output logic                     o_ovf
`ifdef MOUSE_BTN_LEVEL_EN
    ,
    output logic [N_BTN-1:0]         o_btn_level
`endif
);

    localparam int unsigned BW = $clog2(N_BTN);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]    div_q;
    logic             tick;
    logic [N_BTN-1:0] pend_valid, drop, clr, req;
    logic [1:0]       pend_type [N_BTN];
    logic             valid_q, ovf_q, xfer, gnt_found;
    logic [BW-1:0]    btn_q, ptr_q, ptr_eff, gnt_idx, rr_idx;
    logic [1:0]       type_q;
`ifdef MOUSE_BTN_LEVEL_EN
    logic [N_BTN-1:0] active, level_q;
`endif

    assign tick = (div_q == DIV_LAST);

    for (genvar g = 0; g < N_BTN; g++) begin : g_cls
        mouse_btn_classifier #(
            .LONG_MS (LONG_MS),
            .DBL_MS  (DBL_MS)
        ) u_cls (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_tick       (tick),
            .i_pos        (i_pos[g]),
            .i_neg        (i_neg[g]),
            .i_clr        (clr[g]),
            .o_pend_valid (pend_valid[g]),
            .o_pend_type  (pend_type[g]),
            .o_drop       (drop[g])
`ifdef MOUSE_BTN_LEVEL_EN
            ,
            .o_active     (active[g])
`endif
        );
    end

    // The slot being accepted is masked so the next grant starts after it.
    always_comb begin
        xfer    = valid_q & i_evt_ready;
        clr     = '0;
        ptr_eff = ptr_q;
        if (xfer) begin
            clr[btn_q] = 1'b1;
            ptr_eff    = (btn_q == BW'(N_BTN - 1)) ? '0 : btn_q + 1'b1;
        end
        req       = pend_valid & ~clr;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            rr_idx = BW'((32'(ptr_eff) + i) % N_BTN);
            if (!gnt_found && req[rr_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q   <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            btn_q   <= '0;
            type_q  <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            ovf_q <= ovf_q | (|drop);
            if (xfer) ptr_q <= ptr_eff;
            if (!valid_q || i_evt_ready) begin
                valid_q <= gnt_found;
                if (gnt_found) begin
                    btn_q  <= gnt_idx;
                    type_q <= pend_type[gnt_idx];
                end
            end
        end
    end

    assign o_evt_valid = valid_q;
    assign o_evt_btn   = btn_q;
    assign o_evt_type  = type_q;
    assign o_ovf       = ovf_q;

`ifdef MOUSE_BTN_LEVEL_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) level_q <= '0;
        else          level_q <= active;
    end
    assign o_btn_level = level_q;
`endif

endmodule

// File: tb/tb_mouse_btn_ctrl.sv
// Directed bench for mouse_btn_ctrl with a scoreboard of expected events and arrival windows.
module tb_mouse_btn_ctrl;
    import mouse_btn_pkg::*;

    localparam int unsigned TD = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [2:0] i_pos = '0;
    logic [2:0] i_neg = '0;
    logic       i_evt_ready = 1'b0;
    logic       o_evt_valid;
    logic [1:0] o_evt_btn;
    logic [1:0] o_evt_type;
    logic       o_ovf;
`ifdef MOUSE_BTN_LEVEL_EN
    logic [2:0] o_btn_level;
`endif

    mouse_btn_ctrl #(
        .N_BTN    (3),
        .TICK_DIV (TD),
        .LONG_MS  (10),
        .DBL_MS   (5)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pos       (i_pos),
        .i_neg       (i_neg),
        .o_evt_valid (o_evt_valid),
        .i_evt_ready (i_evt_ready),
        .o_evt_btn   (o_evt_btn),
        .o_evt_type  (o_evt_type),
        .o_ovf       (o_ovf)
`ifdef MOUSE_BTN_LEVEL_EN
        ,
        .o_btn_level (o_btn_level)
`endif
    );

    typedef struct {
        int btn;
        int typ;
        int lo;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] p, input logic [2:0] n);
        i_pos = p;
        i_neg = n;
        cycles(1);
        i_pos = '0;
        i_neg = '0;
    endtask

    task automatic expect_evt(input int b, input evt_t t, input int lo, input int hi);
        sb.push_back('{btn: b, typ: int'(t), lo: cyc + lo, hi: cyc + hi});
    endtask

    task automatic drain(input string tag, input int max_c);
        int n = 0;
        while (sb.size() != 0 && n < max_c) begin
            cycles(1);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic click(input logic [2:0] b);
        pulse(b, '0);
        cycles(2);
        pulse('0, b);
        cycles(8 * TD);
    endtask

    // Every accepted transfer must match the oldest expectation, inside its time window.
    always @(negedge i_clk) begin
        if (i_rst_n && o_evt_valid && i_evt_ready) begin
            chk($sformatf("evt_expected btn=%0d type=%0d", o_evt_btn, o_evt_type),
                32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("evt_id cyc=%0d", cyc), {o_evt_btn, o_evt_type},
                    {2'(e.btn), 2'(e.typ)});
                chk($sformatf("evt_time cyc=%0d lo=%0d hi=%0d", cyc, e.lo, e.hi),
                    32'(cyc >= e.lo && cyc <= e.hi), 1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        chk("rst_valid", o_evt_valid, 0);
        chk("rst_btn", o_evt_btn, 0);
        chk("rst_type", o_evt_type, 0);
        chk("rst_ovf", o_ovf, 0);
        i_rst_n = 1'b1;
        i_evt_ready = 1'b1;
        cycles(2);

        // Single click on left.
        pulse(3'b001, '0);
        cycles(8 * TD);
        expect_evt(BTN_LEFT, EvtClick, 16, 30);
        pulse('0, 3'b001);
        drain("click_drain", 40);
        cycles(15 * TD);

        // Double click on left.
        pulse(3'b001, '0);
        cycles(4 * TD);
        pulse('0, 3'b001);
        cycles(2 * TD);
        pulse(3'b001, '0);
        cycles(3 * TD);
        expect_evt(BTN_LEFT, EvtDouble, 0, 8);
        pulse('0, 3'b001);
        drain("double_drain", 20);
        cycles(15 * TD);

        // Long press on right.
        pulse(3'b010, '0);
        expect_evt(BTN_RIGHT, EvtLong, 36, 50);
        cycles(15 * TD);
        expect_evt(BTN_RIGHT, EvtLongEnd, 0, 8);
        pulse('0, 3'b010);
        drain("long_drain", 20);
        cycles(15 * TD);

        // Simultaneous pos+neg and a stray neg are ignored.
        pulse(3'b100, 3'b100);
        cycles(15 * TD);
        pulse('0, 3'b100);
        cycles(15 * TD);

        // Reset returns the pointer to button 0.
        i_rst_n = 1'b0;
        cycles(2);
        i_rst_n = 1'b1;
        cycles(2);

        // Fairness from pointer 0.
        i_evt_ready = 1'b0;
        click(3'b111);
        chk("fair0_valid", o_evt_valid, 1);
        chk("fair0_first", o_evt_btn, 0);
        i_evt_ready = 1'b1;
        expect_evt(0, EvtClick, 0, 0);
        expect_evt(1, EvtClick, 1, 1);
        expect_evt(2, EvtClick, 2, 2);
        drain("fair0_drain", 10);
        cycles(4);

        // Move pointer to 1 with a lone left click.
        expect_evt(BTN_LEFT, EvtClick, 16, 44);
        click(3'b001);
        drain("solo_drain", 20);

        // Fairness from pointer 1.
        i_evt_ready = 1'b0;
        click(3'b111);
        chk("fair1_first", o_evt_btn, 1);
        i_evt_ready = 1'b1;
        expect_evt(1, EvtClick, 0, 0);
        expect_evt(2, EvtClick, 1, 1);
        expect_evt(0, EvtClick, 2, 2);
        drain("fair1_drain", 10);
        cycles(4);

        // Overflow: two clicks on middle while stalled.
        chk("ovf_before", o_ovf, 0);
        i_evt_ready = 1'b0;
        click(3'b100);
        chk("ovf_first_held", o_ovf, 0);
        click(3'b100);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_pending_btn", o_evt_btn, BTN_MID);
        i_evt_ready = 1'b1;
        expect_evt(BTN_MID, EvtClick, 0, 0);
        drain("ovf_drain", 10);
        cycles(10 * TD);
        chk("ovf_sticky", o_ovf, 1);

        // Reset mid-gesture with an event still pending.
        i_evt_ready = 1'b0;
        click(3'b010);
        chk("prerst_valid", o_evt_valid, 1);
        pulse(3'b001, '0);
        cycles(6 * TD);
`ifdef MOUSE_BTN_LEVEL_EN
        chk("prerst_level", o_btn_level, 3'b001);
`endif
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", o_evt_valid, 0);
        chk("midrst_ovf", o_ovf, 0);
`ifdef MOUSE_BTN_LEVEL_EN
        chk("midrst_level", o_btn_level, 3'b000);
`endif
        cycles(2);
        i_rst_n = 1'b1;
        i_evt_ready = 1'b1;
        cycles(15 * TD);
        pulse('0, 3'b001);
        cycles(10 * TD);
        chk("postrst_valid", o_evt_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
